// File: rtl/noc_port_arbiter_mux.sv
// N-input NoC output-port multiplexer: internal arbitration, valid/ready handshakes,
// wormhole packet locking and a single registered output flit.
//
// state  | meaning
// IDLE   | between packets; arbitrate among valid channels every cycle
// LOCKED | mid-packet; only grant_idx may send until its tail flit transfers
module noc_port_arbiter_mux #(
    parameter int NUM_INPUTS       = 3,
    parameter int DATA_PACKET_SIZE = 10,
    parameter int ARB_MODE         = 0,
    parameter int SEL_W            = $clog2(NUM_INPUTS)
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [NUM_INPUTS*DATA_PACKET_SIZE-1:0] in_data,
    input  logic [NUM_INPUTS-1:0]                 in_valid,
    input  logic [NUM_INPUTS-1:0]                 in_last,
    output logic [NUM_INPUTS-1:0]                 in_ready,
    output logic [DATA_PACKET_SIZE-1:0]           out_data,
    output logic                                  out_valid,
    output logic                                  out_last,
    input  logic                                  out_ready,
    output logic [SEL_W-1:0]                      grant_idx,
    output logic                                  locked
);

    typedef enum logic {IDLE, LOCKED} state_t;

    localparam logic [SEL_W:0]   NUM_W    = (SEL_W+1)'(NUM_INPUTS);
    localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NUM_INPUTS - 1);

    state_t                      state;
    state_t                      state_next;
    logic [SEL_W-1:0]            rr_ptr;
    logic [SEL_W-1:0]            rr_sel;
    logic [SEL_W-1:0]            rr_idx;
    logic [SEL_W:0]              rr_sum;
    logic                        rr_found;
    logic [SEL_W-1:0]            fp_sel;
    logic                        fp_found;
    logic [SEL_W-1:0]            sel;
    logic                        sel_valid;
    logic                        load_en;
    logic                        transfer;
    logic [DATA_PACKET_SIZE-1:0] chan_data [NUM_INPUTS];

    always_comb begin
        for (int i = 0; i < NUM_INPUTS; i++) begin
            chan_data[i] = in_data[i*DATA_PACKET_SIZE +: DATA_PACKET_SIZE];
        end
    end

    // Round-robin: first valid channel at or above rr_ptr, wrapping modulo NUM_INPUTS.
    always_comb begin
        rr_sel   = '0;
        rr_found = 1'b0;
        rr_sum   = '0;
        rr_idx   = '0;
        for (int k = 0; k < NUM_INPUTS; k++) begin
            rr_sum = {1'b0, rr_ptr} + (SEL_W+1)'(k);
            if (rr_sum >= NUM_W) begin
                rr_sum = rr_sum - NUM_W;
            end
            rr_idx = rr_sum[SEL_W-1:0];
            if (!rr_found && in_valid[rr_idx]) begin
                rr_found = 1'b1;
                rr_sel   = rr_idx;
            end
        end
    end

    always_comb begin
        fp_sel   = '0;
        fp_found = 1'b0;
        for (int i = NUM_INPUTS - 1; i >= 0; i--) begin
            if (in_valid[i]) begin
                fp_found = 1'b1;
                fp_sel   = SEL_W'(i);
            end
        end
    end

    always_comb begin
        sel       = rr_sel;
        sel_valid = rr_found;
        if (state == LOCKED) begin
            sel       = grant_idx;
            sel_valid = in_valid[grant_idx];
        end else if (ARB_MODE == 1) begin
            sel       = fp_sel;
            sel_valid = fp_found;
        end
    end

    // Gating with reset keeps every channel stalled while the port is held in reset.
    assign load_en  = !out_valid || out_ready;
    assign transfer = reset && load_en && sel_valid;

    always_comb begin
        in_ready = '0;
        if (transfer) begin
            in_ready[sel] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (transfer) begin
            state_next = in_last[sel] ? IDLE : LOCKED;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            grant_idx <= '0;
            rr_ptr    <= '0;
        end else begin
            if (transfer) begin
                out_data  <= chan_data[sel];
                out_last  <= in_last[sel];
                out_valid <= 1'b1;
                grant_idx <= sel;
                if (in_last[sel]) begin
                    rr_ptr <= (sel == LAST_IDX) ? '0 : sel + SEL_W'(1);
                end
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    assign locked = (state == LOCKED);

endmodule

// File: tb/tb_noc_port_arbiter_mux.sv
// Scoreboard bench for noc_port_arbiter_mux: packet-level reference model plus
// directed scenarios (round-robin, wormhole lock, backpressure, fixed priority, reset).
module tb_noc_port_arbiter_mux;

    localparam int N  = 3;
    localparam int W  = 10;
    localparam int SW = 2;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_valid, in_last, in_ready;
    logic [W-1:0]   out_data;
    logic           out_valid, out_last, out_ready, locked;
    logic [SW-1:0]  grant_idx;

    logic [N*W-1:0] fp_data;
    logic [N-1:0]   fp_valid, fp_last, fp_in_ready;
    logic [W-1:0]   fp_out_data;
    logic           fp_out_valid, fp_out_last, fp_out_ready, fp_locked;
    logic [SW-1:0]  fp_grant;

    noc_port_arbiter_mux #(.NUM_INPUTS(N), .DATA_PACKET_SIZE(W), .ARB_MODE(0)) dut_rr (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
        .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid), .out_last(out_last),
        .out_ready(out_ready), .grant_idx(grant_idx), .locked(locked));

    noc_port_arbiter_mux #(.NUM_INPUTS(N), .DATA_PACKET_SIZE(W), .ARB_MODE(1)) dut_fp (
        .clk(clk), .reset(reset), .in_data(fp_data), .in_valid(fp_valid), .in_last(fp_last),
        .in_ready(fp_in_ready), .out_data(fp_out_data), .out_valid(fp_out_valid),
        .out_last(fp_out_last), .out_ready(fp_out_ready), .grant_idx(fp_grant),
        .locked(fp_locked));

    typedef struct {logic [W-1:0] data; logic last;} flit_t;
    typedef struct {logic [W-1:0] data; logic last; int idx;} exp_t;

    flit_t        chq [N][$];
    exp_t         exp_q [$];
    logic [W-1:0] out_log [$];
    exp_t         mon_e;

    int tests = 0;
    int fails = 0;

    // Reference model: packet owner (-1 when free), rotating start pointer, output occupancy.
    int           owner = -1;
    int           ptr = 0;
    bit           m_full = 1'b0;
    logic [N-1:0] pres;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (reset && out_valid && out_ready) begin
            out_log.push_back(out_data);
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_flit: actual=%0h expected=none at %0t", out_data, $time);
            end else begin
                mon_e = exp_q.pop_front();
                check("out_data", 32'(out_data), 32'(mon_e.data));
                check("out_last", 32'(out_last), 32'(mon_e.last));
                check("grant_idx", 32'(grant_idx), 32'(mon_e.idx));
            end
        end
    end

    task automatic model_step();
        logic [N-1:0] er;
        int           g;
        int           idx;
        flit_t        f;
        bit           load;
        er   = '0;
        g    = -1;
        load = !m_full || out_ready;
        if (load) begin
            if (owner >= 0) begin
                if (pres[owner]) g = owner;
            end else begin
                for (int k = 0; k < N; k++) begin
                    idx = (ptr + k) % N;
                    if (g < 0 && pres[idx]) g = idx;
                end
            end
        end
        if (g >= 0) er[g] = 1'b1;
        check("in_ready", 32'(in_ready), 32'(er));
        check("locked", 32'(locked), 32'(owner >= 0));
        check("out_valid", 32'(out_valid), 32'(m_full));
        if (g >= 0) begin
            f = chq[g].pop_front();
            exp_q.push_back('{data: f.data, last: f.last, idx: g});
            if (f.last) begin
                owner = -1;
                ptr   = (g + 1) % N;
            end else begin
                owner = g;
            end
            m_full = 1'b1;
        end else if (out_ready) begin
            m_full = 1'b0;
        end
    endtask

    task automatic run_cycles(input int n, input int pv, input int pr);
        for (int c = 0; c < n; c++) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                pres[i] = (chq[i].size() > 0) && ($urandom_range(99) < pv);
                if (pres[i]) begin
                    in_data[i*W +: W] = chq[i][0].data;
                    in_last[i]        = chq[i][0].last;
                end else begin
                    in_data[i*W +: W] = W'($urandom);
                    in_last[i]        = 1'($urandom);
                end
            end
            in_valid  = pres;
            out_ready = ($urandom_range(99) < pr);
            #1;
            model_step();
        end
    endtask

    task automatic drain(input string name);
        int budget;
        int remaining;
        budget = 300;
        while ((chq[0].size() + chq[1].size() + chq[2].size() + exp_q.size()) > 0 && budget > 0) begin
            run_cycles(1, 100, 100);
            budget--;
        end
        remaining = chq[0].size() + chq[1].size() + chq[2].size() + exp_q.size();
        check(name, 32'(remaining), 32'd0);
    endtask

    task automatic push_flit(input int ch, input int data, input logic last);
        chq[ch].push_back('{data: W'(data), last: last});
    endtask

    task automatic check_seq(input string name, input int base,
                             input int v0, input int v1, input int v2, input int v3, input int cnt);
        int v [4];
        v = '{v0, v1, v2, v3};
        for (int j = 0; j < cnt; j++) begin
            check(name, (base + j < out_log.size()) ? 32'(out_log[base + j]) : 32'hDEAD, 32'(v[j]));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base;
        int len;
        pres         = '0;
        in_data      = '0;
        in_valid     = '1;
        in_last      = '1;
        out_ready    = 1'b1;
        fp_data      = '0;
        fp_valid     = '1;
        fp_last      = '1;
        fp_out_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_data", 32'(out_data), 0);
        check("rst_in_ready", 32'(in_ready), 0);
        check("rst_locked", 32'(locked), 0);
        check("rst_grant", 32'(grant_idx), 0);
        check("rst_fp_in_ready", 32'(fp_in_ready), 0);
        @(posedge clk);
        #1;
        in_valid = '0;
        fp_valid = '0;
        reset    = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("idle_out_valid", 32'(out_valid), 0);
        check("idle_out_data", 32'(out_data), 0);
        check("idle_in_ready", 32'(in_ready), 0);

        // Fixed priority: channel 0 starves channel 2 until it drops valid.
        fp_data = {10'h00C, 10'h3FF, 10'h00A};
        fp_last = 3'b111;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            #1;
            fp_valid = 3'b101;
            #1;
            check("fp_in_ready", 32'(fp_in_ready), 32'b001);
            if (c > 0) begin
                check("fp_out_data", 32'(fp_out_data), 32'h00A);
                check("fp_grant", 32'(fp_grant), 0);
            end
        end
        @(posedge clk);
        #1;
        fp_valid = 3'b100;
        #1;
        check("fp_in_ready_ch2", 32'(fp_in_ready), 32'b100);
        @(posedge clk);
        #1;
        fp_valid = '0;
        check("fp_out_data_ch2", 32'(fp_out_data), 32'h00C);
        check("fp_grant_ch2", 32'(fp_grant), 2);
        check("fp_out_valid_ch2", 32'(fp_out_valid), 1);

        // Round-robin fairness across single-flit packets.
        base = out_log.size();
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < N; i++) push_flit(i, i + 1, 1'b1);
        end
        run_cycles(6, 100, 100);
        drain("rr_drain");
        for (int j = 0; j < 6; j++) begin
            check("rr_seq", (base + j < out_log.size()) ? 32'(out_log[base + j]) : 32'hDEAD, 32'((j % 3) + 1));
        end

        // Wormhole lock: channel 1 packet must not be interleaved with channel 0.
        base = out_log.size();
        push_flit(1, 'h10, 1'b0);
        push_flit(1, 'h11, 1'b0);
        push_flit(1, 'h12, 1'b1);
        run_cycles(1, 100, 100);
        push_flit(0, 'h20, 1'b1);
        run_cycles(5, 100, 100);
        drain("worm_drain");
        check_seq("worm_seq", base, 'h10, 'h11, 'h12, 'h20, 4);

        // Backpressure: output register holds while downstream stalls.
        base = out_log.size();
        push_flit(1, 'h30, 1'b0);
        push_flit(1, 'h31, 1'b0);
        push_flit(1, 'h32, 1'b1);
        run_cycles(1, 100, 100);
        run_cycles(4, 100, 0);
        check("bp_hold_data", 32'(out_data), 32'h30);
        check("bp_hold_valid", 32'(out_valid), 1);
        run_cycles(4, 100, 100);
        drain("bp_drain");
        check_seq("bp_seq", base, 'h30, 'h31, 'h32, 0, 3);

        // Mid-packet reset: lock and held flit are dropped, pointer restarts at 0.
        push_flit(1, 'h40, 1'b0);
        push_flit(1, 'h41, 1'b0);
        push_flit(1, 'h42, 1'b1);
        run_cycles(2, 100, 100);
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("mid_rst_out_valid", 32'(out_valid), 0);
        check("mid_rst_locked", 32'(locked), 0);
        check("mid_rst_in_ready", 32'(in_ready), 0);
        check("mid_rst_out_data", 32'(out_data), 0);
        exp_q.delete();
        for (int i = 0; i < N; i++) chq[i].delete();
        owner    = -1;
        ptr      = 0;
        m_full   = 1'b0;
        pres     = '0;
        in_valid = '0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        base  = out_log.size();
        push_flit(0, 'h05, 1'b1);
        push_flit(1, 'h06, 1'b1);
        run_cycles(2, 100, 100);
        drain("post_rst_drain");
        check_seq("post_rst_seq", base, 'h05, 'h06, 0, 0, 2);

        // Randomized packets with random valid gaps and backpressure.
        for (int blk = 0; blk < 40; blk++) begin
            for (int i = 0; i < N; i++) begin
                if (chq[i].size() < 3) begin
                    len = int'($urandom_range(1, 4));
                    for (int f = 0; f < len; f++) push_flit(i, int'($urandom_range(0, 1023)), f == len - 1);
                end
            end
            run_cycles(10, 70, 75);
        end
        drain("rand_drain");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/noc_port_arbiter_mux.md
Name: noc_port_arbiter_mux

Overview:
- Parametrised N-input output-port multiplexer for the NoC router; the registered successor of the 3-way select mux.
- Replaces external `select` and tri-state idle with internal arbitration, valid/ready handshakes and wormhole packet locking.
- Sits between input-channel buffers and one router output link.
- Output is registered: one flit of storage, one cycle of latency.

Parameters:
- NUM_INPUTS, 3, number of input channels (2..16).
- DATA_PACKET_SIZE, 10, flit width in bits.
- ARB_MODE, 0, arbitration mode: 0 = round-robin, 1 = fixed priority (lowest index wins).
- SEL_W, $clog2(NUM_INPUTS), width of grant index (derived, not overridden).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- in_data  in  NUM_INPUTS*DATA_PACKET_SIZE  flattened input flits; channel i at bits [i*W +: W].
- in_valid  in  NUM_INPUTS  per-channel flit valid.
- in_last  in  NUM_INPUTS  per-channel tail-flit marker.
- in_ready  out  NUM_INPUTS  per-channel accept (combinational).
- out_data  out  DATA_PACKET_SIZE  registered output flit.
- out_valid  out  1  output flit valid.
- out_last  out  1  output tail marker.
- out_ready  in  1  downstream accept.
- grant_idx  out  SEL_W  channel currently owning or last owning the output.
- locked  out  1  high while a multi-flit packet holds the output.

Behaviour:
- Reset (reset=0, async):
  - out_data=0, out_valid=0, out_last=0, grant_idx=0, locked=0.
  - Round-robin pointer rr_ptr=0; state IDLE.
  - No Z drive anywhere.
- load_en = !out_valid || out_ready. A flit transfers from channel i when in_valid[i] && in_ready[i].
- in_ready[i] = load_en && (i == sel) && sel_valid. At most one bit of in_ready is high. in_ready may depend on in_valid.
- Selection in IDLE:
  - ARB_MODE 0: first i with in_valid[i]=1, searching from rr_ptr upward modulo NUM_INPUTS.
  - ARB_MODE 1: lowest i with in_valid[i]=1.
  - sel_valid = 0 if no channel is valid.
- Selection in LOCKED: sel = grant_idx only. sel_valid = in_valid[grant_idx]. Other channels are never serviced, even if the locked channel is idle.
- FSM:
  - IDLE -> LOCKED on a transfer with in_last=0.
  - IDLE stays IDLE on a transfer with in_last=1 (single-flit packet).
  - LOCKED -> IDLE on a transfer with in_last=1.
- On every transfer:
  - out_data <= flit; out_last <= in_last[sel]; out_valid <= 1; grant_idx <= sel.
  - If in_last=1: rr_ptr <= (sel+1) mod NUM_INPUTS (wrap from NUM_INPUTS-1 to 0).
- If out_valid && out_ready and there is no transfer: out_valid <= 0. out_data and out_last hold their values.
- Backpressure: if out_valid && !out_ready, the output register holds, all in_ready=0 and state is frozen.
- Simultaneous drain and load (out_valid && out_ready && transfer): the new flit replaces the old one in the same edge, giving zero bubbles at full throughput.
- locked = (state == LOCKED).
- Latency: a flit accepted at edge k is visible on out_* after edge k.
- Reset asserted mid-packet: the lock is dropped immediately and any flit in the output register is discarded. Senders must restart the packet.

Test Plan:
- Reset/idle: hold reset=0 with in_valid=3'b111 -> out_valid=0, out_data=0, in_ready=0. Release reset with all in_valid=0 -> outputs stay 0.
- Round-robin fairness (N=3, ARB_MODE=0, out_ready=1, all channels sending single-flit packets 0x01/0x02/0x03 with last=1):
  - out_data sequence is 0x01, 0x02, 0x03, 0x01, ...
  - grant_idx cycles 0, 1, 2, 0 with no idle cycles.
- Wormhole lock: channel 1 sends a 3-flit packet 0x10, 0x11, 0x12 (last on 0x12) while channel 0 holds valid with 0x20.
  - Output is 0x10, 0x11, 0x12, then 0x20.
  - locked=1 during the 0x11 and 0x12 cycles.
  - in_ready[0]=0 throughout the packet.
- Backpressure: out_ready=0 for 4 cycles after the first flit -> out_data holds 0x10 and in_ready=0. When out_ready returns to 1, the next flit appears the following cycle. No loss or duplication.
- Fixed priority (ARB_MODE=1): channels 0 and 2 continuously valid with single flits -> only channel 0 is serviced (starvation expected). Drop in_valid[0] -> channel 2 is granted the next cycle.
- Mid-packet reset: assert reset after the second flit of a 3-flit packet -> out_valid=0 and locked=0 immediately. After release, channel 0 single flit 0x05 is granted on the first cycle with rr_ptr=0.
